// File: rtl/br_flow_demux_select_skid.sv
// Demux with a 2-entry skid buffer: one ordered queue feeds all flows, and the head entry is steered to its selected flow.
// push_ready comes straight from state flops, so this block cuts every ready path back to the source.

module br_flow_demux_select_skid_lane #(
   parameter int Width = 1,
   parameter int SelW  = 1,
   parameter int Idx   = 0
) (
   input  logic             main_valid,
   input  logic [SelW-1:0]  main_sel,
   input  logic [Width-1:0] main_data,
   output logic             pop_valid,
   output logic [Width-1:0] pop_data
);
   assign pop_valid = main_valid && (main_sel == SelW'(Idx));
   assign pop_data  = main_data;
endmodule

module br_flow_demux_select_skid #(
   parameter int NumFlows                  = 2,
   parameter int Width                     = 1,
   parameter int EnableAssertFinalNotValid = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic                               push_ready,
   input  logic                               push_valid,
   input  logic [Width-1:0]                   push_data,
   input  logic [$clog2(NumFlows)-1:0]        push_select,
   input  logic [NumFlows-1:0]                pop_ready,
   output logic [NumFlows-1:0]                pop_valid,
   output logic [NumFlows-1:0][Width-1:0]     pop_data
);
   localparam int SelW = $clog2(NumFlows);

   typedef struct packed {
      logic [Width-1:0] data;
      logic [SelW-1:0]  sel;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_e;

   state_e state, state_nxt;
   entry_t main_q, skid_q, push_e;
   logic   main_valid, skid_valid, push_acc, pop;
   logic   load_main_push, load_main_skid, load_skid;

   assign main_valid = (state != EMPTY);
   assign skid_valid = (state == FULL);
   assign push_ready = !skid_valid;
   assign push_e     = '{data: push_data, sel: push_select};
   assign push_acc   = push_valid && push_ready;
   assign pop        = main_valid && pop_ready[main_q.sel];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= EMPTY;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      load_main_push = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: if (push_acc) begin
            load_main_push = 1'b1;
            state_nxt      = ONE;
         end
         ONE: begin
            if (pop && push_acc) begin
               load_main_push = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end else if (push_acc) begin
               load_skid = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: if (pop) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Payload flops carry no reset; validity lives entirely in the state register.
   always_ff @(posedge clk) begin
      if (load_main_push)      main_q <= push_e;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= push_e;
   end

   for (genvar i = 0; i < NumFlows; i++) begin : g_lane
      br_flow_demux_select_skid_lane #(
         .Width (Width),
         .SelW  (SelW),
         .Idx   (i)
      ) u_lane (
         .main_valid (main_valid),
         .main_sel   (main_q.sel),
         .main_data  (main_q.data),
         .pop_valid  (pop_valid[i]),
         .pop_data   (pop_data[i])
      );
   end

`ifndef SYNTHESIS
   a_push_sel_range: assert property (@(posedge clk) disable iff (!rst)
      push_valid |-> int'(push_select) < NumFlows);
   a_push_stable: assert property (@(posedge clk) disable iff (!rst)
      push_valid && !push_ready |=> push_valid && $stable(push_data) && $stable(push_select));
   a_pop_stable: assert property (@(posedge clk) disable iff (!rst)
      main_valid && !pop_ready[main_q.sel] |=> $stable(pop_valid) && $stable(pop_data));
   a_pop_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(pop_valid));

   c_full: cover property (@(posedge clk) disable iff (!rst) state == FULL);
   c_b2b_diff: cover property (@(posedge clk) disable iff (!rst)
      push_acc ##1 (push_acc && push_select != $past(push_select)));
   c_pop_last: cover property (@(posedge clk) disable iff (!rst)
      pop && main_q.sel == SelW'(NumFlows - 1));

   if (EnableAssertFinalNotValid != 0) begin : g_final
      final assert (pop_valid == '0);
   end
`endif
endmodule

// File: tb/tb_br_flow_demux_select_skid.sv
// Directed bench for the select demux skid buffer; a negedge monitor drains an expected-transfer scoreboard.

module tb_br_flow_demux_select_skid;
   localparam int NF = 3;
   localparam int W  = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                push_ready;
   logic                push_valid;
   logic [W-1:0]        push_data;
   logic [1:0]          push_select;
   logic [NF-1:0]       pop_ready;
   logic [NF-1:0]       pop_valid;
   logic [NF-1:0][W-1:0] pop_data;

   typedef struct {
      int unsigned sel;
      logic [W-1:0] data;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   br_flow_demux_select_skid #(
      .NumFlows (NF),
      .Width    (W),
      .EnableAssertFinalNotValid (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .push_ready  (push_ready),
      .push_valid  (push_valid),
      .push_data   (push_data),
      .push_select (push_select),
      .pop_ready   (pop_ready),
      .pop_valid   (pop_valid),
      .pop_data    (pop_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one transfer and hold it until accepted; the expected pop is queued from the arguments.
   task automatic push(input logic [W-1:0] d, input logic [1:0] s);
      push_valid  = 1'b1;
      push_data   = d;
      push_select = s;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (push_ready) begin
            q.push_back('{sel: 32'(s), data: d});
            tick();
            push_valid = 1'b0;
            return;
         end
         tick();
      end
      check("push_timeout", 32'd0, 32'd1);
      push_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      int idx;
      idx = 0;
      if (rst && pop_valid != '0) begin
         for (int i = 0; i < NF; i++) if (pop_valid[i]) idx = i;
         check("pop_onehot0", 32'($onehot0(pop_valid)), 32'd1);
         if (q.size() == 0) begin
            check("pop_unexpected", 32'(pop_valid), 32'd0);
         end else begin
            check("pop_flow", 32'(pop_valid), 32'd1 << q[0].sel);
            check("pop_data", 32'(pop_data[q[0].sel]), 32'(q[0].data));
            if (pop_ready[idx]) void'(q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      push_valid  = 1'b0;
      push_data   = '0;
      push_select = '0;
      pop_ready   = '0;
      #1 rst = 1'b0;
      #1;
      check("reset_pop_valid", 32'(pop_valid), 32'd0);
      check("reset_push_ready", 32'(push_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // single transfer, one-cycle latency
      pop_ready = 3'b111;
      push(8'hA5, 2'd2);
      @(negedge clk);
      check("single_valid", 32'(pop_valid), 32'h4);
      check("single_data", 32'(pop_data[2]), 32'hA5);
      tick();
      @(negedge clk);
      check("single_idle", 32'(pop_valid), 32'd0);
      tick();

      // backpressure fill
      pop_ready = 3'b000;
      push(8'h11, 2'd0);
      push(8'h22, 2'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("fill_push_ready", 32'(push_ready), 32'd0);
         check("fill_pop_valid", 32'(pop_valid), 32'h1);
         check("fill_pop_data", 32'(pop_data[0]), 32'h11);
         tick();
      end

      // drain order
      pop_ready = 3'b111;
      @(negedge clk);
      check("drain0_valid", 32'(pop_valid), 32'h1);
      check("drain0_push_ready", 32'(push_ready), 32'd0);
      tick();
      @(negedge clk);
      check("drain1_valid", 32'(pop_valid), 32'h2);
      check("drain1_data", 32'(pop_data[1]), 32'h22);
      check("drain1_push_ready", 32'(push_ready), 32'd1);
      tick();
      @(negedge clk);
      check("drain_idle", 32'(pop_valid), 32'd0);
      tick();

      // streaming at full rate
      pop_ready = 3'b111;
      for (int i = 0; i < 16; i++) begin
         push_valid  = 1'b1;
         push_data   = 8'(8'h40 + i);
         push_select = 2'(i % 3);
         @(negedge clk);
         check("stream_push_ready", 32'(push_ready), 32'd1);
         if (i > 0) check("stream_pop_active", 32'(|pop_valid), 32'd1);
         q.push_back('{sel: 32'(i % 3), data: 8'(8'h40 + i)});
         tick();
      end
      push_valid = 1'b0;
      @(negedge clk);
      check("stream_last_pop", 32'(|pop_valid), 32'd1);
      tick();
      @(negedge clk);
      check("stream_idle", 32'(pop_valid), 32'd0);
      check("stream_sb_empty", 32'(q.size()), 32'd0);
      tick();

      // head-of-line blocking
      pop_ready = 3'b110;
      push(8'h33, 2'd0);
      push(8'h44, 2'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hol_blocked", 32'(pop_valid), 32'h1);
         tick();
      end
      pop_ready = 3'b111;
      @(negedge clk);
      check("hol_release0", 32'(pop_valid), 32'h1);
      tick();
      @(negedge clk);
      check("hol_release1", 32'(pop_valid), 32'h2);
      check("hol_release1_data", 32'(pop_data[1]), 32'h44);
      tick();
      @(negedge clk);
      check("hol_idle", 32'(pop_valid), 32'd0);
      tick();

      // asynchronous reset while full
      pop_ready = 3'b000;
      push(8'h55, 2'd2);
      push(8'h66, 2'd0);
      @(negedge clk);
      check("rstfull_push_ready", 32'(push_ready), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("rstfull_async_pop_valid", 32'(pop_valid), 32'd0);
      check("rstfull_async_push_ready", 32'(push_ready), 32'd1);
      q.delete();
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("rstfull_after_pop_valid", 32'(pop_valid), 32'd0);
      check("rstfull_after_push_ready", 32'(push_ready), 32'd1);
      tick();
      pop_ready = 3'b111;
      push(8'h77, 2'd1);
      @(negedge clk);
      check("post_rst_valid", 32'(pop_valid), 32'h2);
      check("post_rst_data", 32'(pop_data[1]), 32'h77);
      tick();
      @(negedge clk);
      check("post_rst_idle", 32'(pop_valid), 32'd0);
      check("final_sb_empty", 32'(q.size()), 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/br_flow_demux_select_skid.md
BR_FLOW_DEMUX_SELECT_SKID -- requirements
Module: br_flow_demux_select_skid

Interface
REQ-001 SHALL have parameter NumFlows, default 2, number of output flows; must be >= 2.
REQ-002 SHALL have parameter Width, default 1, payload bits per transfer; must be >= 1.
REQ-003 SHALL have parameter EnableAssertFinalNotValid, default 1; if 1, assert no pop_valid bit is set at end of test.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assertion, active-low (asserted when 0).
REQ-006 SHALL have port push_ready  output  1  block can accept a transfer this cycle.
REQ-007 SHALL have port push_valid  input  1  upstream transfer offered, typically the output of a flow mux.
REQ-008 SHALL have port push_data  input  Width  payload.
REQ-009 SHALL have port push_select  input  $clog2(NumFlows)  destination flow index.
REQ-010 SHALL have port pop_ready  input  NumFlows  per-flow downstream ready.
REQ-011 SHALL have port pop_valid  output  NumFlows  per-flow valid, at most one bit set.
REQ-012 SHALL have port pop_data  output  NumFlows x Width  per-flow payload.

Function
REQ-013 SHALL implement a 2-entry buffer: main entry (valid, data, select) and skid entry (valid, data, select).
REQ-014 SHALL drive push_ready = !skid_valid, directly from a flop with no combinational path from pop_ready or push_valid.
REQ-015 SHALL drive pop_valid[i] = main_valid && (main_select == i); pop_data[i] = main_data for every i.
REQ-016 SHALL define push accept = push_valid && push_ready, and pop = main_valid && pop_ready[main_select].
REQ-017 SHALL have state EMPTY (neither entry valid), ONE (main only), FULL (main and skid).
REQ-018 SHALL, in EMPTY with push accept, load push into main -> ONE; pop_valid rises next cycle (1-cycle latency).
REQ-019 SHALL, in ONE: pop with push -> main reloaded from push, stays ONE; pop only -> EMPTY; push only -> push into skid -> FULL; neither -> hold.
REQ-020 SHALL, in FULL (push_ready=0): pop -> skid moves to main, skid cleared -> ONE; no pop -> hold.
REQ-021 SHALL preserve push order globally across all flows, including transfers to different flows.
REQ-022 SHALL sustain one transfer per cycle when the destination ready is continuously high.
REQ-023 SHALL hold main select and data stable while pop_valid is set and pop_ready[main_select] is low.
REQ-024 SHALL never set more than one pop_valid bit in a cycle.
REQ-025 SHALL assert (integration) push_valid |-> push_select < NumFlows, and that push_valid, push_data, push_select are stable while push_valid && !push_ready.
REQ-026 SHALL assert (implementation) pop_valid and pop_data stable under backpressure, and $onehot0(pop_valid).
REQ-027 SHALL cover: FULL reached, back-to-back pushes to different flows, pop to flow NumFlows-1.

Reset
REQ-028 SHALL, while rst is 0, immediately clear main_valid and skid_valid: pop_valid = 0, push_ready = 1.
REQ-029 SHALL have no reset requirement on data/select flops; pop_data is don't-care while pop_valid is 0.
REQ-030 SHALL, when rst asserts mid-operation, discard buffered entries with no pop; first push accept after deassertion follows REQ-018.

Verification (NumFlows=3, Width=8)
REQ-031 SHALL cover single transfer: push 0xA5 sel=2 with all ready=1 -> next cycle pop_valid=3'b100, pop_data[2]=0xA5; following cycle pop_valid=0.
REQ-032 SHALL cover backpressure fill: pop_ready=0, push 0x11 sel=0 then 0x22 sel=1 -> push_ready=0 after the second accept; pop_valid=3'b001 stable for 5 cycles.
REQ-033 SHALL cover drain order: from the REQ-032 state, raise pop_ready=3'b111 -> 0x11 on flow 0, then 0x22 on flow 1 next cycle; push_ready returns to 1 one cycle after the first pop.
REQ-034 SHALL cover streaming: 16 consecutive pushes, sel cycling 0,1,2, all ready=1 -> 16 pops in 16 consecutive cycles, in order, push_ready=1 throughout.
REQ-035 SHALL cover head-of-line blocking: pop_ready=3'b110, push sel=0 then sel=1 -> flow 1 is not served until pop_ready[0] rises.
REQ-036 SHALL cover reset in FULL: drive rst=0 -> pop_valid=0 and push_ready=1 without waiting for a clock edge; after release, buffer is EMPTY.
